door_input_conditioner: RTL

Input conditioning stage directly upstream of the door FSM. Synchronizes and debounces the four raw door inputs: presence sensor, emergency stop, open limit and closed limit. Produces clean levels that drive the FSM's `ui_in[3:0]`, plus a sticky fault flag that is raised when both limit switches read active at once. The emergency-stop channel uses a fail-safe fast assert path.

---
 rtl/door_pkg.sv | 18 +
 rtl/door_debounce_ch.sv | 60 ++++++
 rtl/door_input_conditioner.sv | 76 +++++++
 3 files changed

// File: rtl/door_pkg.sv
// Shared channel map for the door input conditioner and the door FSM.
// Bit order of every 4-bit door vector follows the CH_* constants below.
package door_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_SEN = 0;
   localparam int CH_SE  = 1;
   localparam int CH_LA  = 2;
   localparam int CH_LC  = 3;

   typedef logic [NUM_CH-1:0] ch_vec_t;

   // Both limit switches active at once can only be a wiring or sensor fault.
   function automatic logic limit_conflict(input ch_vec_t v);
      return v[CH_LA] & v[CH_LC];
   endfunction

endpackage

// File: rtl/door_debounce_ch.sv
// One door input channel: two-flop synchronizer, debounce counter, clean level.
// FAST_ASSERT=1 lets a synchronized high bypass the debounce on the rising side.
module door_debounce_ch #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FAST_ASSERT     = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic raw,
   output logic clean
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1_r;
   logic             s2_r;
   logic [CNT_W-1:0] cnt_r;
   logic             clean_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             clean_nxt_s;

   // Next counter / clean level; the counter is cleared before it can wrap.
   always_comb begin
      cnt_nxt_s   = cnt_r;
      clean_nxt_s = clean_r;
      if (s2_r == clean_r) begin
         cnt_nxt_s = CNT_ZERO;
      end else if ((FAST_ASSERT != 0) && (s2_r == 1'b1) && (clean_r == 1'b0)) begin
         clean_nxt_s = 1'b1;
         cnt_nxt_s   = CNT_ZERO;
      end else if (cnt_r == CNT_MAX) begin
         clean_nxt_s = s2_r;
         cnt_nxt_s   = CNT_ZERO;
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end
   end

   // Synchronizer and debounce state; everything holds while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r    <= 1'b0;
         s2_r    <= 1'b0;
         cnt_r   <= CNT_ZERO;
         clean_r <= 1'b0;
      end else if (ena) begin
         s1_r    <= raw;
         s2_r    <= s1_r;
         cnt_r   <= cnt_nxt_s;
         clean_r <= clean_nxt_s;
      end
   end

   assign clean = clean_r;

endmodule

// File: rtl/door_input_conditioner.sv
// Conditions the four raw door inputs for the door FSM and flags limit faults.
// Define DOOR_IN_EDGE_EN to build the rising-edge pulse outputs on edge_o.
module door_input_conditioner
   import door_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NUM_CH-1:0] raw_in,
   input  logic              fault_clr,
   output logic [NUM_CH-1:0] clean_o,
   output logic              fault_o,
   output logic [NUM_CH-1:0] edge_o
);

   ch_vec_t clean_s;
   logic    fault_r;
   logic    fault_nxt_s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      door_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .FAST_ASSERT     ((i == CH_SE) ? 1 : 0)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .ena   (ena),
         .raw   (raw_in[i]),
         .clean (clean_s[i])
      );
   end

   // Sticky fault: a live limit conflict beats a clear request.
   always_comb begin
      fault_nxt_s = fault_r;
      if (limit_conflict(clean_s)) begin
         fault_nxt_s = 1'b1;
      end else if (fault_clr) begin
         fault_nxt_s = 1'b0;
      end else begin
         fault_nxt_s = fault_r;
      end
   end

   // Fault flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_r <= 1'b0;
      end else if (ena) begin
         fault_r <= fault_nxt_s;
      end
   end

`ifdef DOOR_IN_EDGE_EN
   ch_vec_t clean_prev_r;

   // Previous clean levels for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clean_prev_r <= {NUM_CH{1'b0}};
      end else if (ena) begin
         clean_prev_r <= clean_s;
      end
   end

   assign edge_o = clean_s & ~clean_prev_r;
`else
   assign edge_o = {NUM_CH{1'b0}};
`endif

   assign clean_o = clean_s;
   assign fault_o = fault_r;

endmodule
